seq_max_switch_monitor: RTL and testbench
=========================================

Name: seq_max_switch_monitor

Overview:
Downstream consumer of the 8-bit max-switching edge detector's 1-bit `max_switching` flag.
- Tracks total and consecutive max-switching events.
- Raises a sticky `alarm` when a run of consecutive events reaches a threshold.
- Holds the alarm until software/control acknowledges it via `ack`.
- Sits between the detector and the power/throttle controller.

Parameters:
- RUN_THRESH, 4, consecutive-event count that triggers the alarm; legal 1..255
- CNT_NBITS, 8, width of total_count; legal 1..32
- WINDOW, 8, sliding-window depth in cycles (used only with the optional feature); legal 2..64

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- max_switching  input  1  event flag from the upstream detector, sampled each rising edge
- ack  input  1  alarm acknowledge, level-sampled each rising edge
- total_count  output  CNT_NBITS  saturating count of sampled events
- run_len  output  8  current consecutive-event run length, saturating at 255
- alarm  output  1  sticky alarm
- state  output  2  FSM state encoding: IDLE=0, RUN=1, ALARM=2, HOLD=3
- win_count  output  $clog2(WINDOW+1)  events in the last WINDOW samples

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high: port `reset` asserted forces all registers to 0 and the FSM to IDLE immediately, independent of `clk`.
- Reset values: total_count=0, run_len=0, alarm=0, state=0, win_count=0.
- All outputs are registered. Let ms = max_switching sampled at edge N; its effect is visible after edge N, i.e. 1-cycle latency.
- total_count: +1 on each edge with ms=1. Saturates at all-ones and never wraps. Not cleared by ack.
- run_len: if ms=1, next run_len = min(run_len+1, 255); if ms=0, next run_len = 0.
- alarm: registered, equal to (next state == ALARM or HOLD).
- FSM transitions, evaluated on each edge:
  - IDLE:
    - ms=1 and RUN_THRESH==1 -> ALARM
    - ms=1 otherwise -> RUN
    - ms=0 -> IDLE
  - RUN:
    - ms=1 and run_len+1 >= RUN_THRESH -> ALARM
    - ms=1 otherwise -> RUN
    - ms=0 -> IDLE
  - ALARM:
    - ms=1 -> ALARM; ack is ignored while the condition persists
    - ms=0 and ack=1 -> IDLE
    - ms=0 and ack=0 -> HOLD
  - HOLD:
    - ack=0 and ms=0 -> HOLD
    - ack=0 and ms=1 -> ALARM
    - ack=1 and ms=0 -> IDLE
    - ack=1 and ms=1 -> RUN, or ALARM if RUN_THRESH==1
- ack in IDLE or RUN: no effect.
- run_len updates identically in every state. In particular, a new run starting in HOLD counts from 1.
- Boundary conditions:
  - Simultaneous ms and ack: resolved per the transition table above.
  - run_len saturation does not alter FSM behaviour.
- Reset mid-run or mid-alarm: all state is lost immediately; first post-reset sample is treated as in IDLE.

Optional Feature:
- Macro: SEQ_MAX_SWITCH_MON_WINDOW_EN.
- Defined:
  - A WINDOW-bit shift register holds the last WINDOW ms samples.
  - win_count is maintained incrementally: win_count + ms − oldest bit.
  - Range 0..WINDOW; reset clears both the shift register and the count.
- Undefined:
  - No shift register is built; win_count is tied to 0.
  - The port remains present.

Test Plan (RUN_THRESH=4, CNT_NBITS=8, WINDOW=8):
1. Reset, then ms=0 for 5 cycles -> total_count=0, run_len=0, alarm=0, state=0 every cycle.
2. ms=1,1,1,0 -> run_len=1,2,3,0; state=1,1,1,0; alarm stays 0; total_count ends at 3.
3. ms=1 for 4 cycles with ack=1 held throughout, then continue ms=1 -> after 4th sample state=2, alarm=1, run_len=4; alarm stays 1 despite ack.
4. From ALARM:
   - ms=0, ack=0 -> state=3, alarm=1, run_len=0.
   - Then ms=1, ack=0 -> state=2, run_len=1.
   - Then ms=0, ack=1 -> state=0, alarm=0.
5. ms=1 for 300 cycles -> total_count=255 and run_len=255 (both saturated, no wrap). Assert reset mid-sequence (between edges) -> all outputs 0 before the next clk edge.
6. With the macro defined, ms pattern 1,0,1,1,0,0,0,0,0,0 -> win_count=1,1,2,3,3,3,3,3,2,2. Without the macro, win_count=0 throughout.

Source files
------------

// File: rtl/seq_max_switch_monitor.sv
// Max-switching event monitor: event counters, run-length alarm FSM, optional window.
// Optional sliding-window count enabled by defining SEQ_MAX_SWITCH_MON_WINDOW_EN.
module seq_max_switch_monitor #(
    parameter int RUN_THRESH = 4,
    parameter int CNT_NBITS  = 8,
    parameter int WINDOW     = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         max_switching,
    input  logic                         ack,
    output logic [CNT_NBITS-1:0]         total_count,
    output logic [7:0]                   run_len,
    output logic                         alarm,
    output logic [1:0]                   state,
    output logic [$clog2(WINDOW+1)-1:0]  win_count
);

    localparam int   WCW      = $clog2(WINDOW + 1);
    localparam logic ONE_SHOT = (RUN_THRESH == 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ALARM = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [8:0] run_inc;
    logic       run_hit;

    // 9-bit compare so a saturated run_len still reads as past threshold
    assign run_inc = {1'b0, run_len} + 9'd1;
    assign run_hit = (run_inc >= 9'(RUN_THRESH));
    assign state   = state_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (max_switching)
                    state_d = ONE_SHOT ? ALARM : RUN;
            end
            RUN: begin
                if (!max_switching)
                    state_d = IDLE;
                else if (run_hit)
                    state_d = ALARM;
                else
                    state_d = RUN;
            end
            ALARM: begin
                if (!max_switching)
                    state_d = ack ? IDLE : HOLD;
            end
            HOLD: begin
                if (!ack)
                    state_d = max_switching ? ALARM : HOLD;
                else if (max_switching)
                    state_d = ONE_SHOT ? ALARM : RUN;
                else
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            alarm       <= 1'b0;
            total_count <= '0;
            run_len     <= '0;
        end else begin
            state_q <= state_d;
            alarm   <= (state_d == ALARM) || (state_d == HOLD);
            if (max_switching && (total_count != '1))
                total_count <= total_count + CNT_NBITS'(1);
            if (!max_switching)
                run_len <= 8'd0;
            else if (run_len != 8'hFF)
                run_len <= run_len + 8'd1;
        end
    end

`ifdef SEQ_MAX_SWITCH_MON_WINDOW_EN
    logic [WINDOW-1:0] hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist      <= '0;
            win_count <= '0;
        end else begin
            hist      <= {hist[WINDOW-2:0], max_switching};
            win_count <= win_count + WCW'(max_switching)
                         - WCW'(hist[WINDOW-1]);
        end
    end
`else
    assign win_count = '0;
`endif

endmodule

// File: tb/tb_seq_max_switch_monitor.sv
// Scoreboard bench for seq_max_switch_monitor (RUN_THRESH=4, CNT_NBITS=8, WINDOW=8).
// Expected outputs come from a behavioural model queued at drive time.
module tb_seq_max_switch_monitor;

    localparam int RT  = 4;
    localparam int CN  = 8;
    localparam int WIN = 8;
    localparam int WW  = $clog2(WIN + 1);

    typedef struct {
        logic [CN-1:0] cnt;
        logic [7:0]    run;
        logic          alm;
        logic [1:0]    st;
        logic [WW-1:0] win;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ms = 1'b0;
    logic          ack = 1'b0;
    logic [CN-1:0] total_count;
    logic [7:0]    run_len;
    logic          alarm;
    logic [1:0]    state;
    logic [WW-1:0] win_count;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb[$];

    int             m_cnt;
    int             m_run;
    int             m_st;
    logic [WIN-1:0] m_hist;

    seq_max_switch_monitor #(
        .RUN_THRESH(RT),
        .CNT_NBITS (CN),
        .WINDOW    (WIN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .max_switching(ms),
        .ack          (ack),
        .total_count  (total_count),
        .run_len      (run_len),
        .alarm        (alarm),
        .state        (state),
        .win_count    (win_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_run  = 0;
        m_st   = 0;
        m_hist = '0;
        sb.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cnt"}, int'(total_count), 0);
        check({tag, "_run"}, int'(run_len), 0);
        check({tag, "_alarm"}, int'(alarm), 0);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_win"}, int'(win_count), 0);
    endtask

    task automatic step(input logic s, input logic a);
        exp_t e;
        exp_t g;
        int   nst;
        ms  = s;
        ack = a;
        nst = m_st;
        case (m_st)
            0: nst = s ? ((RT == 1) ? 2 : 1) : 0;
            1: nst = s ? ((m_run + 1 >= RT) ? 2 : 1) : 0;
            2: nst = s ? 2 : (a ? 0 : 3);
            3: if (!a) nst = s ? 2 : 3;
               else    nst = s ? ((RT == 1) ? 2 : 1) : 0;
            default: nst = 0;
        endcase
        m_st = nst;
        if (s && m_cnt < (2 ** CN) - 1) m_cnt++;
        m_run  = s ? ((m_run < 255) ? m_run + 1 : 255) : 0;
        m_hist = {m_hist[WIN-2:0], s};
        e.cnt = CN'(m_cnt);
        e.run = 8'(m_run);
        e.alm = (m_st >= 2);
        e.st  = 2'(m_st);
`ifdef SEQ_MAX_SWITCH_MON_WINDOW_EN
        e.win = WW'($countones(m_hist));
`else
        e.win = '0;
`endif
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check("sb_cnt", int'(total_count), int'(g.cnt));
        check("sb_run", int'(run_len), int'(g.run));
        check("sb_alarm", int'(alarm), int'(g.alm));
        check("sb_state", int'(state), int'(g.st));
        check("sb_win", int'(win_count), int'(g.win));
    endtask

    initial begin
        int pat[10];
        int wexp[10];
        pat  = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        wexp = '{1, 1, 2, 3, 3, 3, 3, 3, 2, 2};
        model_reset();
        #12;
        check_zero("rst");
        @(negedge clk);
        reset = 1'b0;

        repeat (5) step(1'b0, 1'b0);

        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("run3", int'(run_len), 3);
        step(1'b0, 1'b0);
        check("cnt3", int'(total_count), 3);

        repeat (4) step(1'b1, 1'b1);
        check("alarm_state", int'(state), 2);
        check("alarm_flag", int'(alarm), 1);
        check("alarm_run", int'(run_len), 4);
        step(1'b1, 1'b1);
        check("ack_ignored", int'(alarm), 1);

        step(1'b0, 1'b0);
        check("hold_state", int'(state), 3);
        check("hold_alarm", int'(alarm), 1);
        check("hold_run", int'(run_len), 0);
        step(1'b1, 1'b0);
        check("rearm_state", int'(state), 2);
        check("rearm_run", int'(run_len), 1);
        step(1'b0, 1'b1);
        check("ack_state", int'(state), 0);
        check("ack_alarm", int'(alarm), 0);

        repeat (4) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        check("hold_ack_run", int'(state), 1);
        step(1'b0, 1'b0);

        repeat (300) step(1'b1, 1'b0);
        check("sat_cnt", int'(total_count), 255);
        check("sat_run", int'(run_len), 255);
        check("sat_alarm", int'(alarm), 1);

        #3;
        reset = 1'b1;
        #1;
        check_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("held_rst");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step(pat[i] != 0, 1'b0);
`ifdef SEQ_MAX_SWITCH_MON_WINDOW_EN
            check("win_pat", int'(win_count), wexp[i]);
`else
            check("win_pat", int'(win_count), 0);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
